fg_bbox_tracker: RTL and testbench

Per-frame foreground bounding-box tracker that sits directly downstream of the background-subtraction stage. It consumes that stage's 1-bit foreground decision, one per accepted pixel in raster order, and reconstructs the raster position itself. At the end of each frame it reports the box enclosing all foreground pixels, the foreground pixel count and a found flag to the overlay/VGA logic.

---
 rtl/fg_bbox_tracker.sv | 312 +++++++++++++++++++++++++++++++
 tb/tb_fg_bbox_tracker.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fg_bbox_tracker.sv
// fg_bbox_tracker: per-frame bounding box of foreground pixels.
//
// Consumes one foreground decision per accepted pixel in raster order and rebuilds the
// raster position locally. i_valid && i_sof marks pixel (0,0) and always starts a new
// frame. When the last pixel of a frame (H_ACTIVE-1, V_ACTIVE-1) is accepted, the frame
// result is reported with a one-cycle o_bbox_valid pulse. Report outputs hold between
// pulses.
//
// Ports:
//   i_clk, i_rst_n       clock, synchronous active-low reset
//   i_valid              pixel decision presented this cycle
//   i_sof, i_fg          start-of-frame marker and foreground flag, qualified by i_valid
//   o_bbox_valid         report pulse
//   o_found              frame count >= MIN_PIXELS
//   o_x_min..o_y_max     inclusive box limits (all 0 when not found)
//   o_count              foreground pixel count of the reported frame
//   o_cx, o_cy           centroid (only with FG_BBOX_CENTROID_EN)
//
// Build option FG_BBOX_CENTROID_EN: adds coordinate sums, two 29-step restoring dividers
// and the centroid outputs. The report then appears 31 cycles after the last pixel
// instead of 1.
module fg_bbox_tracker #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned MIN_PIXELS = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic        i_sof,
  input  logic        i_fg,
  output logic        o_bbox_valid,
  output logic        o_found,
  output logic [9:0]  o_x_min,
  output logic [9:0]  o_x_max,
  output logic [9:0]  o_y_min,
  output logic [9:0]  o_y_max,
  output logic [18:0] o_count
`ifdef FG_BBOX_CENTROID_EN
  ,
  output logic [9:0]  o_cx,
  output logic [9:0]  o_cy
`endif
);

  localparam int unsigned CW = 10;
  localparam int unsigned NW = 19;
  localparam logic [CW-1:0] XLast  = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] YLast  = CW'(V_ACTIVE - 1);
  localparam logic [NW-1:0] MinCnt = NW'(MIN_PIXELS);

`ifdef FG_BBOX_CENTROID_EN
  localparam int unsigned SW = 29;
  localparam logic [4:0] DivIters = 5'd29;
  // StDivide: divider running and no new frame started yet.
  typedef enum logic [1:0] {StIdle, StAccum, StDivide} state_e;
`else
  typedef enum logic [1:0] {StIdle, StAccum} state_e;
`endif

  state_e state_q, state_d;

  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [CW-1:0] xmin_q, xmin_d, xmax_q, xmax_d, ymin_q, ymin_d, ymax_q, ymax_d;
  logic [NW-1:0] cnt_q, cnt_d;

  logic [CW-1:0] pix_x, pix_y;
  logic          acc_en, last_pix;
  logic [CW-1:0] b_xmin, b_xmax, b_ymin, b_ymax;
  logic [NW-1:0] b_cnt;
  logic [CW-1:0] f_xmin, f_xmax, f_ymin, f_ymax;
  logic [NW-1:0] f_cnt;
  logic          f_found;

  logic          rep_valid_q, rep_found_q;
  logic [CW-1:0] rep_xmin_q, rep_xmax_q, rep_ymin_q, rep_ymax_q;
  logic [NW-1:0] rep_cnt_q;

`ifdef FG_BBOX_CENTROID_EN
  logic [SW-1:0] sumx_q, sumx_d, sumy_q, sumy_d;
  logic [SW-1:0] b_sumx, b_sumy, f_sumx, f_sumy;
  logic          busy_q, div_done;
  logic [4:0]    div_cnt_q;
  logic          snap_found_q;
  logic [NW-1:0] snap_cnt_q;
  logic [CW-1:0] snap_xmin_q, snap_xmax_q, snap_ymin_q, snap_ymax_q;
  logic [SW-1:0] qx_q, qy_q;
  logic [NW-1:0] rx_q, ry_q;
  logic [NW+SW-1:0] step_x, step_y;
  logic [CW-1:0] rep_cx_q, rep_cy_q;

  // One restoring-division iteration; returns {remainder, quotient/dividend shift reg}.
  function automatic logic [NW+SW-1:0] div_step(input logic [NW-1:0] rem,
                                                input logic [SW-1:0] quo,
                                                input logic [NW-1:0] den);
    logic [NW:0] trial;
    trial = {rem, quo[SW-1]};
    if (trial >= {1'b0, den}) begin
      div_step = {NW'(trial - {1'b0, den}), quo[SW-2:0], 1'b1};
    end else begin
      div_step = {trial[NW-1:0], quo[SW-2:0], 1'b0};
    end
  endfunction

  assign div_done = busy_q && (div_cnt_q == DivIters);
  assign step_x   = div_step(rx_q, qx_q, snap_cnt_q);
  assign step_y   = div_step(ry_q, qy_q, snap_cnt_q);
`endif

  // Datapath: raster position, accumulators and this pixel's contribution.
  always_comb begin
    pix_x    = i_sof ? '0 : x_q;
    pix_y    = i_sof ? '0 : y_q;
    acc_en   = i_valid && (i_sof || (state_q == StAccum));
    last_pix = acc_en && (pix_x == XLast) && (pix_y == YLast);

    // A sof pixel starts from fresh accumulators, dropping any partial frame.
    if (i_sof) begin
      b_xmin = XLast;
      b_xmax = '0;
      b_ymin = YLast;
      b_ymax = '0;
      b_cnt  = '0;
    end else begin
      b_xmin = xmin_q;
      b_xmax = xmax_q;
      b_ymin = ymin_q;
      b_ymax = ymax_q;
      b_cnt  = cnt_q;
    end

    f_xmin  = (i_fg && (pix_x < b_xmin)) ? pix_x : b_xmin;
    f_xmax  = (i_fg && (pix_x > b_xmax)) ? pix_x : b_xmax;
    f_ymin  = (i_fg && (pix_y < b_ymin)) ? pix_y : b_ymin;
    f_ymax  = (i_fg && (pix_y > b_ymax)) ? pix_y : b_ymax;
    f_cnt   = b_cnt + NW'(i_fg);
    f_found = (f_cnt >= MinCnt);

    xmin_d = xmin_q;
    xmax_d = xmax_q;
    ymin_d = ymin_q;
    ymax_d = ymax_q;
    cnt_d  = cnt_q;
    if (last_pix) begin
      xmin_d = XLast;
      xmax_d = '0;
      ymin_d = YLast;
      ymax_d = '0;
      cnt_d  = '0;
    end else if (acc_en) begin
      xmin_d = f_xmin;
      xmax_d = f_xmax;
      ymin_d = f_ymin;
      ymax_d = f_ymax;
      cnt_d  = f_cnt;
    end

`ifdef FG_BBOX_CENTROID_EN
    b_sumx = i_sof ? '0 : sumx_q;
    b_sumy = i_sof ? '0 : sumy_q;
    f_sumx = b_sumx + (i_fg ? SW'(pix_x) : '0);
    f_sumy = b_sumy + (i_fg ? SW'(pix_y) : '0);
    sumx_d = sumx_q;
    sumy_d = sumy_q;
    if (last_pix) begin
      sumx_d = '0;
      sumy_d = '0;
    end else if (acc_en) begin
      sumx_d = f_sumx;
      sumy_d = f_sumy;
    end
`endif

    // Position advances on every accepted input, even while waiting for sof.
    x_d = x_q;
    y_d = y_q;
    if (i_valid) begin
      if (pix_x == XLast) begin
        x_d = '0;
        y_d = (pix_y == YLast) ? '0 : pix_y + 1'b1;
      end else begin
        x_d = pix_x + 1'b1;
        y_d = pix_y;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (last_pix) begin
`ifdef FG_BBOX_CENTROID_EN
      state_d = StDivide;
`else
      state_d = StIdle;
`endif
    end else if (i_valid && i_sof) begin
      state_d = StAccum;
`ifdef FG_BBOX_CENTROID_EN
    end else if ((state_q == StDivide) && div_done) begin
      state_d = StIdle;
`endif
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      xmin_q      <= XLast;
      xmax_q      <= '0;
      ymin_q      <= YLast;
      ymax_q      <= '0;
      cnt_q       <= '0;
      rep_valid_q <= 1'b0;
      rep_found_q <= 1'b0;
      rep_xmin_q  <= '0;
      rep_xmax_q  <= '0;
      rep_ymin_q  <= '0;
      rep_ymax_q  <= '0;
      rep_cnt_q   <= '0;
`ifdef FG_BBOX_CENTROID_EN
      sumx_q       <= '0;
      sumy_q       <= '0;
      busy_q       <= 1'b0;
      div_cnt_q    <= '0;
      snap_found_q <= 1'b0;
      snap_cnt_q   <= '0;
      snap_xmin_q  <= '0;
      snap_xmax_q  <= '0;
      snap_ymin_q  <= '0;
      snap_ymax_q  <= '0;
      qx_q         <= '0;
      qy_q         <= '0;
      rx_q         <= '0;
      ry_q         <= '0;
      rep_cx_q     <= '0;
      rep_cy_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      xmin_q      <= xmin_d;
      xmax_q      <= xmax_d;
      ymin_q      <= ymin_d;
      ymax_q      <= ymax_d;
      cnt_q       <= cnt_d;
      rep_valid_q <= 1'b0;
`ifdef FG_BBOX_CENTROID_EN
      sumx_q <= sumx_d;
      sumy_q <= sumy_d;
      if (last_pix) begin
        busy_q       <= 1'b1;
        div_cnt_q    <= '0;
        snap_found_q <= f_found;
        snap_cnt_q   <= f_cnt;
        snap_xmin_q  <= f_found ? f_xmin : '0;
        snap_xmax_q  <= f_found ? f_xmax : '0;
        snap_ymin_q  <= f_found ? f_ymin : '0;
        snap_ymax_q  <= f_found ? f_ymax : '0;
        qx_q         <= f_sumx;
        qy_q         <= f_sumy;
        rx_q         <= '0;
        ry_q         <= '0;
      end else if (div_done) begin
        busy_q      <= 1'b0;
        rep_valid_q <= 1'b1;
        rep_found_q <= snap_found_q;
        rep_cnt_q   <= snap_cnt_q;
        rep_xmin_q  <= snap_xmin_q;
        rep_xmax_q  <= snap_xmax_q;
        rep_ymin_q  <= snap_ymin_q;
        rep_ymax_q  <= snap_ymax_q;
        // Quotient is bounded by the largest coordinate, so the low bits are exact.
        rep_cx_q    <= snap_found_q ? qx_q[CW-1:0] : '0;
        rep_cy_q    <= snap_found_q ? qy_q[CW-1:0] : '0;
      end else if (busy_q) begin
        div_cnt_q <= div_cnt_q + 5'd1;
        // Not-found frames skip the divide (count may be zero).
        if (snap_found_q) begin
          {rx_q, qx_q} <= step_x;
          {ry_q, qy_q} <= step_y;
        end
      end
`else
      if (last_pix) begin
        rep_valid_q <= 1'b1;
        rep_found_q <= f_found;
        rep_cnt_q   <= f_cnt;
        rep_xmin_q  <= f_found ? f_xmin : '0;
        rep_xmax_q  <= f_found ? f_xmax : '0;
        rep_ymin_q  <= f_found ? f_ymin : '0;
        rep_ymax_q  <= f_found ? f_ymax : '0;
      end
`endif
    end
  end

  assign o_bbox_valid = rep_valid_q;
  assign o_found      = rep_found_q;
  assign o_x_min      = rep_xmin_q;
  assign o_x_max      = rep_xmax_q;
  assign o_y_min      = rep_ymin_q;
  assign o_y_max      = rep_ymax_q;
  assign o_count      = rep_cnt_q;
`ifdef FG_BBOX_CENTROID_EN
  assign o_cx         = rep_cx_q;
  assign o_cy         = rep_cy_q;
`endif

endmodule

// File: tb/tb_fg_bbox_tracker.sv
// Bench for fg_bbox_tracker on a reduced 32x24 raster. A queue-based frame model turns
// the driven pixel stream into expected reports (cycle, flags, box, count, centroid) and
// a negedge monitor collects every o_bbox_valid pulse for comparison.
module tb_fg_bbox_tracker;

  localparam int H    = 32;
  localparam int V    = 24;
  localparam int MINP = 8;
`ifdef FG_BBOX_CENTROID_EN
  localparam int Lat = 30;
`else
  localparam int Lat = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, valid, sof, fg;
  logic        bbox_valid, found;
  logic [9:0]  x_min, x_max, y_min, y_max;
  logic [18:0] count;
`ifdef FG_BBOX_CENTROID_EN
  logic [9:0]  cx, cy;
`endif

  fg_bbox_tracker #(
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .MIN_PIXELS(MINP)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (valid),
    .i_sof       (sof),
    .i_fg        (fg),
    .o_bbox_valid(bbox_valid),
    .o_found     (found),
    .o_x_min     (x_min),
    .o_x_max     (x_max),
    .o_y_min     (y_min),
    .o_y_max     (y_max),
    .o_count     (count)
`ifdef FG_BBOX_CENTROID_EN
    ,
    .o_cx        (cx),
    .o_cy        (cy)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cyc, found, xmin, xmax, ymin, ymax, count, cx, cy;
  } rep_t;

  rep_t exp_q[$];
  rep_t obs_q[$];
  rep_t mon;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Frame model state
  bit   in_frame = 1'b0;
  int   px = 0, py = 0;
  int   fx[$], fy[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bbox_valid !== 1'b0) begin
      mon.cyc   = cyc;
      mon.found = 32'(found);
      mon.xmin  = 32'(x_min);
      mon.xmax  = 32'(x_max);
      mon.ymin  = 32'(y_min);
      mon.ymax  = 32'(y_max);
      mon.count = 32'(count);
`ifdef FG_BBOX_CENTROID_EN
      mon.cx    = 32'(cx);
      mon.cy    = 32'(cy);
`else
      mon.cx    = 0;
      mon.cy    = 0;
`endif
      obs_q.push_back(mon);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_report(input int at);
    rep_t r;
    int   n;
    n       = fx.size();
    r.cyc   = at;
    r.count = n;
    r.found = (n >= MINP) ? 1 : 0;
    r.xmin  = 0;
    r.xmax  = 0;
    r.ymin  = 0;
    r.ymax  = 0;
    r.cx    = 0;
    r.cy    = 0;
    if (n >= MINP) begin
      int lx, hx, ly, hy, sx, sy;
      lx = H - 1; hx = 0; ly = V - 1; hy = 0; sx = 0; sy = 0;
      for (int i = 0; i < n; i++) begin
        if (fx[i] < lx) lx = fx[i];
        if (fx[i] > hx) hx = fx[i];
        if (fy[i] < ly) ly = fy[i];
        if (fy[i] > hy) hy = fy[i];
        sx += fx[i];
        sy += fy[i];
      end
      r.xmin = lx;
      r.xmax = hx;
      r.ymin = ly;
      r.ymax = hy;
`ifdef FG_BBOX_CENTROID_EN
      r.cx   = sx / n;
      r.cy   = sy / n;
`endif
    end
    exp_q.push_back(r);
  endtask

  // One clock cycle of stimulus; the model follows the frame rules directly.
  task automatic drive(input bit v, input bit s, input bit f);
    @(negedge clk);
    valid = v;
    sof   = s;
    fg    = f;
    if (v) begin
      if (s) begin
        in_frame = 1'b1;
        px = 0;
        py = 0;
        fx.delete();
        fy.delete();
      end
      if (in_frame) begin
        if (f) begin
          fx.push_back(px);
          fy.push_back(py);
        end
        if (px == H - 1 && py == V - 1) begin
          push_report(cyc + 1 + Lat);
          in_frame = 1'b0;
        end
      end
      px++;
      if (px == H) begin
        px = 0;
        py = (py + 1) % V;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    valid = 1'b0;
    sof   = 1'b0;
    fg    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    in_frame = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  function automatic bit fg_at(input int mode, input int x, input int y, input int dens);
    bit corner;
    corner = (x == 0 && y == 0) || (x == H - 1 && y == V - 1);
    case (mode)
      0:       return x >= 10 && x <= 19 && y >= 5 && y <= 14;
      1:       return (y % 2 == 1) && y <= 13 && x == 2 * y;
      2:       return corner;
      3:       return corner || (x == y && x >= 5 && x <= 10);
      4:       return x == y && x >= 5 && x <= 12;
      5:       return $urandom_range(99, 0) < dens;
      default: return 1'b0;
    endcase
  endfunction

  // Full frame starting with sof; idle gaps carry junk sof/fg with valid low.
  task automatic frame(input int mode, input int gmin, input int gmax, input int dens);
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        repeat ($urandom_range(gmax, gmin))
          drive(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        drive(1'b1, (x == 0 && y == 0), fg_at(mode, x, y, dens));
      end
    end
  endtask

  // Frame start followed by n-1 pixels; the next sof aborts it.
  task automatic partial(input int n, input bit rnd);
    for (int p = 0; p < n; p++) begin
      drive(1'b1, (p == 0), rnd ? 1'($urandom_range(1, 0)) : ((p / H) < 10));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".valid"}, 32'(bbox_valid), 0);
    chk({tag, ".found"}, 32'(found), 0);
    chk({tag, ".xmin"}, 32'(x_min), 0);
    chk({tag, ".xmax"}, 32'(x_max), 0);
    chk({tag, ".ymin"}, 32'(y_min), 0);
    chk({tag, ".ymax"}, 32'(y_max), 0);
    chk({tag, ".count"}, 32'(count), 0);
`ifdef FG_BBOX_CENTROID_EN
    chk({tag, ".cx"}, 32'(cx), 0);
    chk({tag, ".cy"}, 32'(cy), 0);
`endif
  endtask

  task automatic verify(input string tag);
    rep_t e;
    repeat (Lat + 6) drive(1'b0, 1'b0, 1'b0);
    #1;
    chk({tag, ".pulses"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk({tag, ".cycle"}, obs_q[i].cyc, exp_q[i].cyc);
      chk({tag, ".found"}, obs_q[i].found, exp_q[i].found);
      chk({tag, ".xmin"}, obs_q[i].xmin, exp_q[i].xmin);
      chk({tag, ".xmax"}, obs_q[i].xmax, exp_q[i].xmax);
      chk({tag, ".ymin"}, obs_q[i].ymin, exp_q[i].ymin);
      chk({tag, ".ymax"}, obs_q[i].ymax, exp_q[i].ymax);
      chk({tag, ".count"}, obs_q[i].count, exp_q[i].count);
      chk({tag, ".cx"}, obs_q[i].cx, exp_q[i].cx);
      chk({tag, ".cy"}, obs_q[i].cy, exp_q[i].cy);
    end
    if (exp_q.size() > 0) begin
      e = exp_q[exp_q.size() - 1];
      chk({tag, ".hold_count"}, 32'(count), e.count);
      chk({tag, ".hold_xmax"}, 32'(x_max), e.xmax);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int dens_tab[4];
    dens_tab = '{1, 3, 20, 60};
    rst_n = 1'b0;
    valid = 1'b0;
    sof   = 1'b0;
    fg    = 1'b0;

    do_reset();
    #1;
    chk_zero("reset");

    // Foreground without any sof never produces a report.
    repeat (1000) drive(1'b1, 1'b0, 1'b1);
    verify("nosof");
    chk_zero("nosof");

    frame(0, 3, 3, 0);
    verify("rect");

    frame(1, 0, 1, 0);
    verify("sparse");

    frame(2, 0, 0, 0);
    verify("corner2");

    frame(3, 0, 0, 0);
    verify("corner8");

    partial(10 * H + 20, 1'b0);
    frame(4, 0, 1, 0);
    verify("midsof");

    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(2, 0) == 0) begin
        repeat ($urandom_range(50, 1)) drive(1'b1, 1'b0, 1'($urandom_range(1, 0)));
      end
      if (k % 3 == 1) partial($urandom_range(H * V - 2, 1), 1'b1);
      frame(5, 0, k % 3, dens_tab[k % 4]);
    end
    verify("random");

`ifdef FG_BBOX_CENTROID_EN
    frame(0, 0, 0, 0);
    repeat (9) drive(1'b0, 1'b0, 1'b0);
    do_reset();
    verify("rstdiv");
    chk_zero("rstdiv");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
